nmcu_out_drain: RTL and testbench
=================================

Name: nmcu_out_drain

Overview:
- Output stage directly downstream of the 2x2-kernel, 4x4-input near-memory compute unit.
- Captures one tile of NUM_OUT 32-bit signed accumulator results in parallel.
- Applies optional ReLU, then a rounding arithmetic right shift, then saturation to signed 8-bit.
- Streams the results one byte per beat, with a write address, over a valid/ready interface to the activation memory write port.

Parameters:
- NUM_OUT, 9, results per tile (3x3 output map)
- ACC_W, 32, accumulator width per result
- OUT_W, 8, requantized output width (signed)
- ADDR_W, 16, output address width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  tile present on in_data
- in_ready  out  1  block can accept a tile
- in_data  in  NUM_OUT*ACC_W  element k = in_data[k*ACC_W +: ACC_W], k=0 top-left, row-major
- cfg_shift  in  5  right-shift amount, 0..31
- cfg_relu  in  1  clamp negative accumulators to 0 before shifting
- cfg_base_addr  in  ADDR_W  address of element 0
- out_valid  out  1  out_data/out_addr valid
- out_ready  in  1  consumer accepts beat
- out_data  out  OUT_W  requantized element
- out_addr  out  ADDR_W  cfg_base_addr + index, modulo 2^ADDR_W
- out_last  out  1  high on the beat for element NUM_OUT-1
- busy  out  1  high while in DRAIN
- sat_flag  out  1  sticky; set if any transferred beat of the current tile clipped

Behaviour:
- Reset: state=IDLE, idx=0, in_ready=1, out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0, sat_flag=0.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: register in_data, cfg_shift, cfg_relu, cfg_base_addr; set idx=0; clear sat_flag; go to DRAIN.
- State DRAIN:
  - in_ready=0, out_valid=1, busy=1.
  - out_data, out_addr and out_last are driven from registered state only, with no combinational path from out_ready.
  - A beat transfers when out_valid && out_ready; then idx increments.
  - A transfer with idx==NUM_OUT-1 returns the block to IDLE.
- Latency and throughput:
  - First out_valid is high the cycle after the capture edge.
  - Minimum NUM_OUT+1 cycles per tile.
- Backpressure: while out_valid && !out_ready, out_data, out_addr and out_last hold stable. No beat is skipped or duplicated.
- Config changes during DRAIN are ignored; the values captured with the tile apply to the whole tile.
- Requantization per element x (signed ACC_W):
  - r = (cfg_relu && x<0) ? 0 : x.
  - If shift>0: y = (r + 2^(shift-1)) >>> shift, computed in ACC_W+1 bits so the rounding add cannot overflow.
  - If shift==0: y = r.
  - Saturate y to [-128,127]. A clip sets sat_flag when that beat transfers.
  - A ReLU clamp alone does not set sat_flag.
- out_addr wraps modulo 2^ADDR_W.
- Reset mid-DRAIN: next cycle is IDLE with the reset values above; the partial tile is discarded with no further beats. in_valid during the rst cycle is ignored.
- in_valid asserted during DRAIN is not accepted and waits for in_ready.

Decomposition:
- Package nmcu_pkg holds:
  - constants NUM_OUT, ACC_W, OUT_W, ADDR_W
  - state enum {IDLE, DRAIN}
  - a function round_shift_sat(x, shift, relu) returning {sat, byte}
- Sub-module nmcu_requant: purely combinational single-element ReLU/round/shift/saturate. Instantiated once on the element selected by idx; this keeps the element mux plus one requantizer instead of NUM_OUT copies.

Test Plan:
- Ramp: element k = 16*k, shift=4, relu=0, base=0x0100, out_ready=1. Expect beats 0..8 at addresses 0x0100..0x0108; out_last only on the 9th beat; in_ready high again the cycle after the 9th beat; sat_flag=0.
- Rounding: elements 24, 23, -24, -25, 8, -8 with shift=4. Expect 2, 1, -1, -2, 1, 0.
- Saturation and ReLU:
  - 5000 and -5000 with shift=0, relu=0: expect 127 and -128, sat_flag=1.
  - Same tile with relu=1: expect 127 and 0.
  - Tile with all elements -100, relu=1: all outputs 0, sat_flag stays 0.
- Backpressure: drop out_ready for 3 cycles while idx=4. Expect out_data and out_addr frozen at element 4 / base+4, all 9 beats delivered exactly once, in order.
- Address wrap: base=0xFFFC. Expect addresses FFFC, FFFD, FFFE, FFFF, 0000..0004.
- Mid-drain reset: assert rst for 1 cycle after 3 beats. Expect out_valid=0 and in_ready=1 next cycle. A following tile starts at element 0 / base address; sat_flag starts at 0.

Source files
------------

// File: rtl/nmcu_pkg.sv
// Shared constants, FSM state type and the requantization helper for the
// near-memory compute unit output drain.
package nmcu_pkg;

    localparam int unsigned NUM_OUT = 9;
    localparam int unsigned ACC_W   = 32;
    localparam int unsigned OUT_W   = 8;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned SHIFT_W = 5;
    localparam int unsigned IDX_W   = $clog2(NUM_OUT);

    typedef enum logic {
        StIdle,
        StDrain
    } state_e;

    // Returns {sat, byte}: optional ReLU, round-half-up arithmetic shift, clip to signed OUT_W.
    function automatic logic [OUT_W:0] round_shift_sat(
        input logic [ACC_W-1:0]   x,
        input logic [SHIFT_W-1:0] shift,
        input logic               relu
    );
        logic signed [ACC_W:0] r;
        logic signed [ACC_W:0] rnd;
        logic signed [ACC_W:0] y;
        logic signed [ACC_W:0] max_v;
        logic signed [ACC_W:0] min_v;
        logic                  sat;
        logic [OUT_W-1:0]      q;

        max_v              = '0;
        max_v[OUT_W-2:0]   = '1;
        min_v              = '1;
        min_v[OUT_W-2:0]   = '0;

        // One extra bit of headroom so the rounding add cannot wrap.
        r = (relu && x[ACC_W-1]) ? '0 : {x[ACC_W-1], x};
        if (shift != '0) begin
            rnd = {{ACC_W{1'b0}}, 1'b1} << (shift - 5'd1);
            y   = (r + rnd) >>> shift;
        end else begin
            rnd = '0;
            y   = r;
        end

        if (y > max_v) begin
            sat = 1'b1;
            q   = max_v[OUT_W-1:0];
        end else if (y < min_v) begin
            sat = 1'b1;
            q   = min_v[OUT_W-1:0];
        end else begin
            sat = 1'b0;
            q   = y[OUT_W-1:0];
        end
        return {sat, q};
    endfunction

endpackage

// File: rtl/nmcu_requant.sv
// Single-element requantizer: ReLU, rounding right shift, signed saturation.
module nmcu_requant
    import nmcu_pkg::*;
(
    input  logic [ACC_W-1:0]   i_x,
    input  logic [SHIFT_W-1:0] i_shift,
    input  logic               i_relu,
    output logic [OUT_W-1:0]   o_data,
    output logic               o_sat
);

    logic [OUT_W:0] w_res;

    // Pure function of the inputs; no state here.
    always_comb begin
        w_res  = round_shift_sat(i_x, i_shift, i_relu);
        o_sat  = w_res[OUT_W];
        o_data = w_res[OUT_W-1:0];
    end

endmodule

// File: rtl/nmcu_out_drain.sv
// Output drain: captures a tile of accumulators, then streams requantized bytes
// with addresses over a valid/ready port, one element per beat.
module nmcu_out_drain
    import nmcu_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [NUM_OUT*ACC_W-1:0] i_in_data,
    input  logic [SHIFT_W-1:0]       i_cfg_shift,
    input  logic                     i_cfg_relu,
    input  logic [ADDR_W-1:0]        i_cfg_base_addr,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [OUT_W-1:0]         o_out_data,
    output logic [ADDR_W-1:0]        o_out_addr,
    output logic                     o_out_last,
    output logic                     o_busy,
    output logic                     o_sat_flag
);

    state_e             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [ACC_W-1:0]   r_tile [NUM_OUT];
    logic [SHIFT_W-1:0] r_shift;
    logic               r_relu;
    logic [ADDR_W-1:0]  r_base;
    logic               r_sat;

    logic [ACC_W-1:0]   w_elem;
    logic [OUT_W-1:0]   w_q;
    logic               w_clip;
    logic               w_is_last;

    // Select the element currently being drained.
    always_comb begin
        w_elem = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_elem = r_tile[k];
            end
        end
    end

    nmcu_requant u_requant (
        .i_x     (w_elem),
        .i_shift (r_shift),
        .i_relu  (r_relu),
        .o_data  (w_q),
        .o_sat   (w_clip)
    );

    assign w_is_last = (r_idx == IDX_W'(NUM_OUT - 1));

    // Outputs come only from registered state, so out_ready never reaches them.
    always_comb begin
        o_in_ready  = (r_state == StIdle);
        o_out_valid = (r_state == StDrain);
        o_busy      = (r_state == StDrain);
        o_out_last  = (r_state == StDrain) && w_is_last;
        o_out_data  = w_q;
        o_out_addr  = r_base + ADDR_W'(r_idx);
        o_sat_flag  = r_sat;
    end

    // Capture/drain FSM with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_shift <= '0;
            r_relu  <= 1'b0;
            r_base  <= '0;
            r_sat   <= 1'b0;
            for (int k = 0; k < NUM_OUT; k++) begin
                r_tile[k] <= '0;
            end
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_in_valid) begin
                        for (int k = 0; k < NUM_OUT; k++) begin
                            r_tile[k] <= i_in_data[k*ACC_W +: ACC_W];
                        end
                        r_shift <= i_cfg_shift;
                        r_relu  <= i_cfg_relu;
                        r_base  <= i_cfg_base_addr;
                        r_idx   <= '0;
                        r_sat   <= 1'b0;
                        r_state <= StDrain;
                    end
                end
                StDrain: begin
                    if (i_out_ready) begin
                        if (w_clip) begin
                            r_sat <= 1'b1;
                        end
                        if (w_is_last) begin
                            r_idx   <= '0;
                            r_state <= StIdle;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nmcu_out_drain.sv
// Directed bench for nmcu_out_drain with hand-computed expected bytes.
module tb_nmcu_out_drain;

    localparam int N = 9;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N*32-1:0] in_data;
    logic [4:0]    cfg_shift;
    logic          cfg_relu;
    logic [15:0]   cfg_base_addr;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic [15:0]   out_addr;
    logic          out_last;
    logic          busy;
    logic          sat_flag;

    int n_total;
    int n_bad;

    logic [31:0] tile_v [N];
    logic [7:0]  exp_v  [N];

    nmcu_out_drain dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_in_valid      (in_valid),
        .o_in_ready      (in_ready),
        .i_in_data       (in_data),
        .i_cfg_shift     (cfg_shift),
        .i_cfg_relu      (cfg_relu),
        .i_cfg_base_addr (cfg_base_addr),
        .o_out_valid     (out_valid),
        .i_out_ready     (out_ready),
        .o_out_data      (out_data),
        .o_out_addr      (out_addr),
        .o_out_last      (out_last),
        .o_busy          (busy),
        .o_sat_flag      (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check one beat's outputs against the model for element j.
    task automatic check_beat(input int j, input logic [15:0] base);
        check_eq($sformatf("valid[%0d]", j), 32'(out_valid), 32'd1);
        check_eq($sformatf("data[%0d]", j), 32'(out_data), 32'(exp_v[j]));
        check_eq($sformatf("addr[%0d]", j), 32'(out_addr), 32'(16'(base + 16'(j))));
        check_eq($sformatf("last[%0d]", j), 32'(out_last), (j == N - 1) ? 32'd1 : 32'd0);
    endtask

    // Present tile_v for one capture edge, then scramble config/data to prove it was latched.
    task automatic send_tile(input logic [4:0] sh, input logic relu, input logic [15:0] base);
        for (int k = 0; k < N; k++) in_data[k*32 +: 32] = tile_v[k];
        cfg_shift     = sh;
        cfg_relu      = relu;
        cfg_base_addr = base;
        in_valid      = 1'b1;
        check_eq("in_ready_pre", 32'(in_ready), 32'd1);
        tick();
        in_valid      = 1'b0;
        cfg_shift     = ~sh;
        cfg_relu      = ~relu;
        cfg_base_addr = ~base;
        in_data       = ~in_data;
        check_eq("busy", 32'(busy), 32'd1);
        check_eq("in_ready_drain", 32'(in_ready), 32'd0);
    endtask

    task automatic run_tile(input logic [4:0] sh, input logic relu, input logic [15:0] base,
                            input logic exp_sat, input int stall_at);
        send_tile(sh, relu, base);
        for (int j = 0; j < N; j++) begin
            if (j == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    check_beat(j, base);
                    tick();
                end
                out_ready = 1'b1;
            end
            check_beat(j, base);
            tick();
        end
        check_eq("in_ready_post", 32'(in_ready), 32'd1);
        check_eq("valid_post", 32'(out_valid), 32'd0);
        check_eq("busy_post", 32'(busy), 32'd0);
        check_eq("sat_flag", 32'(sat_flag), 32'(exp_sat));
    endtask

    initial begin
        n_total       = 0;
        n_bad         = 0;
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_data       = '0;
        cfg_shift     = '0;
        cfg_relu      = 1'b0;
        cfg_base_addr = '0;
        out_ready     = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_addr", 32'(out_addr), 32'd0);
        check_eq("rst_last", 32'(out_last), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_sat", 32'(sat_flag), 32'd0);

        // Ramp: (16k + 8) >>> 4 = k.
        for (int k = 0; k < N; k++) begin
            tile_v[k] = 32'(16 * k);
            exp_v[k]  = 8'(k);
        end
        run_tile(5'd4, 1'b0, 16'h0100, 1'b0, -1);

        // Rounding with a 3-cycle stall on element 4.
        tile_v = '{32'd24, 32'd23, -32'sd24, -32'sd25, 32'd8, -32'sd8, 32'd0, 32'd40, -32'sd40};
        exp_v  = '{8'd2, 8'd1, 8'hFF, 8'hFE, 8'd1, 8'd0, 8'd0, 8'd3, 8'hFE};
        run_tile(5'd4, 1'b0, 16'h0200, 1'b0, 4);

        // Saturation, no ReLU.
        tile_v = '{32'd5000, -32'sd5000, 32'd100, -32'sd100, 32'd127, -32'sd128,
                   32'd128, -32'sd129, 32'd0};
        exp_v  = '{8'h7F, 8'h80, 8'h64, 8'h9C, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h00};
        run_tile(5'd0, 1'b0, 16'h0000, 1'b1, -1);

        // Same tile with ReLU.
        exp_v  = '{8'h7F, 8'h00, 8'h64, 8'h00, 8'h7F, 8'h00, 8'h7F, 8'h00, 8'h00};
        run_tile(5'd0, 1'b1, 16'h0040, 1'b1, -1);

        // ReLU clamp alone never saturates; also checks address wrap.
        for (int k = 0; k < N; k++) begin
            tile_v[k] = -32'sd100;
            exp_v[k]  = 8'h00;
        end
        run_tile(5'd0, 1'b1, 16'hFFFC, 1'b0, -1);

        // Shift of 31: rounding add needs the extra bit.
        tile_v = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h4000_0000, 32'h3FFF_FFFF,
                   32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        exp_v  = '{8'h01, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_tile(5'd31, 1'b0, 16'h0300, 1'b0, -1);

        // Mid-drain reset after 3 beats of a saturating tile.
        tile_v = '{32'd5000, -32'sd5000, 32'd100, -32'sd100, 32'd127, -32'sd128,
                   32'd128, -32'sd129, 32'd0};
        exp_v  = '{8'h7F, 8'h80, 8'h64, 8'h9C, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h00};
        send_tile(5'd0, 1'b0, 16'h0500);
        for (int j = 0; j < 3; j++) begin
            check_beat(j, 16'h0500);
            tick();
        end
        check_eq("mid_sat", 32'(sat_flag), 32'd1);
        for (int k = 0; k < N; k++) in_data[k*32 +: 32] = 32'd1;
        rst      = 1'b1;
        in_valid = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check_eq("mrst_valid", 32'(out_valid), 32'd0);
        check_eq("mrst_in_ready", 32'(in_ready), 32'd1);
        check_eq("mrst_sat", 32'(sat_flag), 32'd0);
        check_eq("mrst_addr", 32'(out_addr), 32'd0);
        tick();
        check_eq("mrst_idle", 32'(out_valid), 32'd0);

        for (int k = 0; k < N; k++) begin
            tile_v[k] = 32'(16 * k);
            exp_v[k]  = 8'(k);
        end
        run_tile(5'd4, 1'b0, 16'h0100, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
